control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_control_sequencer.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// ---------------------------------------------------------------------------
// control_sequencer
//
// Purpose: fetches 8-bit instructions from program memory over a
// valid/ready byte interface, decodes them, and produces one cycle of
// datapath control per instruction (register bank moves, immediate loads,
// ALU operations into A, and output strobes). LDI takes a second byte as
// its immediate. HALT freezes the sequencer until reset.
//
// Ports:
//   clk             - single clock, all state changes on its rising edge
//   reset           - synchronous active-low reset
//   instr_data      - instruction/immediate byte from program memory
//   instr_valid     - instr_data is valid this cycle
//   instr_ready     - sequencer accepts a byte this cycle
//   pc              - address of the next byte to fetch
//   acc_sel         - 1: load from bank source path, 0: load from ALU result
//   source_sel      - bank source select (000-011 = A-D, 100 = immediate)
//   destination_sel - one-hot register load enables (bit0 = A .. bit3 = D)
//   alu_b_sel       - ALU B operand (00 = zero, 01 = B, 10 = C, 11 = D)
//   bank_out_sel    - bank output register select (A-D)
//   alu_op          - ADD/SUB/AND/OR/XOR = 000..100
//   imm_data        - latched immediate byte
//   out_strobe      - one-cycle pulse, bank output valid
//   illegal_op      - one-cycle pulse, undefined opcode decoded
//   halted          - high while halted
// ---------------------------------------------------------------------------
module control_sequencer #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] instr_data,
  input  logic       instr_valid,
  output logic       instr_ready,
  output logic [7:0] pc,
  output logic       acc_sel,
  output logic [2:0] source_sel,
  output logic [3:0] destination_sel,
  output logic [1:0] alu_b_sel,
  output logic [1:0] bank_out_sel,
  output logic [2:0] alu_op,
  output logic [7:0] imm_data,
  output logic       out_strobe,
  output logic       illegal_op,
  output logic       halted
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_FETCH_IMM,
    S_EXECUTE,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_MOV  = 4'b0001;
  localparam logic [3:0] OP_LDI  = 4'b0010;
  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_OUT  = 4'b1000;
  localparam logic [3:0] OP_HALT = 4'b1111;

  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] imm_q, imm_d;

  logic       instr_ready_q, instr_ready_d;
  logic       acc_sel_q, acc_sel_d;
  logic [2:0] source_sel_q, source_sel_d;
  logic [3:0] destination_sel_q, destination_sel_d;
  logic [1:0] alu_b_sel_q, alu_b_sel_d;
  logic [1:0] bank_out_sel_q, bank_out_sel_d;
  logic [2:0] alu_op_q, alu_op_d;
  logic       out_strobe_q, out_strobe_d;
  logic       illegal_op_q, illegal_op_d;
  logic       halted_q, halted_d;

  logic [3:0] opcode;
  logic [1:0] dst;
  logic [1:0] src;

  assign opcode = ir_d[7:4];
  assign dst    = ir_d[3:2];
  assign src    = ir_d[1:0];

  // Next-state logic. All outputs are registered, so they are computed here
  // from the state being entered (state_d) rather than the current state;
  // that way the control word is present for exactly the EXECUTE cycle.
  always_comb begin
    state_d           = state_q;
    pc_d              = pc_q;
    ir_d              = ir_q;
    imm_d             = imm_q;
    instr_ready_d     = 1'b0;
    acc_sel_d         = 1'b0;
    source_sel_d      = 3'b000;
    destination_sel_d = 4'b0000;
    alu_b_sel_d       = 2'b00;
    bank_out_sel_d    = 2'b00;
    alu_op_d          = 3'b000;
    out_strobe_d      = 1'b0;
    illegal_op_d      = 1'b0;
    halted_d          = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (instr_valid) begin
          ir_d    = instr_data;
          pc_d    = pc_q + 8'd1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = (ir_q[7:4] == OP_LDI) ? S_FETCH_IMM : S_EXECUTE;
      end
      S_FETCH_IMM: begin
        if (instr_valid) begin
          imm_d   = instr_data;
          pc_d    = pc_q + 8'd1;
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        state_d = (ir_q[7:4] == OP_HALT) ? S_HALT : S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    instr_ready_d = (state_d == S_FETCH) || (state_d == S_FETCH_IMM);
    halted_d      = (state_d == S_HALT);

    // Control word for the instruction about to execute. NOP and HALT
    // assert nothing; undefined opcodes only raise illegal_op.
    if (state_d == S_EXECUTE) begin
      if (opcode == OP_MOV) begin
        source_sel_d      = {1'b0, src};
        destination_sel_d = 4'b0001 << dst;
        acc_sel_d         = 1'b1;
      end else if (opcode == OP_LDI) begin
        source_sel_d      = 3'b100;
        destination_sel_d = 4'b0001 << dst;
        acc_sel_d         = 1'b1;
      end else if ((opcode >= OP_ADD) && (opcode <= OP_XOR)) begin
        alu_b_sel_d       = src;
        alu_op_d          = opcode[2:0] - 3'd3;
        destination_sel_d = 4'b0001;
      end else if (opcode == OP_OUT) begin
        bank_out_sel_d    = src;
        out_strobe_d      = 1'b1;
      end else if ((opcode != OP_NOP) && (opcode != OP_HALT)) begin
        illegal_op_d      = 1'b1;
      end
    end
  end

  // State and output registers. Reset wins over any concurrent transfer,
  // which is what discards a half-fetched LDI.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q           <= S_FETCH;
      pc_q              <= RESET_PC;
      ir_q              <= 8'h00;
      imm_q             <= 8'h00;
      instr_ready_q     <= 1'b1;
      acc_sel_q         <= 1'b0;
      source_sel_q      <= 3'b000;
      destination_sel_q <= 4'b0000;
      alu_b_sel_q       <= 2'b00;
      bank_out_sel_q    <= 2'b00;
      alu_op_q          <= 3'b000;
      out_strobe_q      <= 1'b0;
      illegal_op_q      <= 1'b0;
      halted_q          <= 1'b0;
    end else begin
      state_q           <= state_d;
      pc_q              <= pc_d;
      ir_q              <= ir_d;
      imm_q             <= imm_d;
      instr_ready_q     <= instr_ready_d;
      acc_sel_q         <= acc_sel_d;
      source_sel_q      <= source_sel_d;
      destination_sel_q <= destination_sel_d;
      alu_b_sel_q       <= alu_b_sel_d;
      bank_out_sel_q    <= bank_out_sel_d;
      alu_op_q          <= alu_op_d;
      out_strobe_q      <= out_strobe_d;
      illegal_op_q      <= illegal_op_d;
      halted_q          <= halted_d;
    end
  end

  assign instr_ready     = instr_ready_q;
  assign pc              = pc_q;
  assign acc_sel         = acc_sel_q;
  assign source_sel      = source_sel_q;
  assign destination_sel = destination_sel_q;
  assign alu_b_sel       = alu_b_sel_q;
  assign bank_out_sel    = bank_out_sel_q;
  assign alu_op          = alu_op_q;
  assign imm_data        = imm_q;
  assign out_strobe      = out_strobe_q;
  assign illegal_op      = illegal_op_q;
  assign halted          = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
// ---------------------------------------------------------------------------
// tb_control_sequencer
//
// Purpose: exercises control_sequencer with directed instruction scenarios
// and a random instruction stream. Expected control words come from an
// instruction-level decode of the byte; expected timing follows the
// fetch / decode / immediate / execute cycle rules. A second instance with
// RESET_PC = FF covers pc wrap and HALT.
// ---------------------------------------------------------------------------
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;

  logic [7:0] instr_data = 8'h00;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [7:0] pc;
  logic       acc_sel;
  logic [2:0] source_sel;
  logic [3:0] destination_sel;
  logic [1:0] alu_b_sel;
  logic [1:0] bank_out_sel;
  logic [2:0] alu_op;
  logic [7:0] imm_data;
  logic       out_strobe;
  logic       illegal_op;
  logic       halted;

  logic [7:0] instr_data_ff = 8'h00;
  logic       instr_valid_ff = 1'b0;
  logic       instr_ready_ff;
  logic [7:0] pc_ff;
  logic       acc_sel_ff;
  logic [2:0] source_sel_ff;
  logic [3:0] destination_sel_ff;
  logic [1:0] alu_b_sel_ff;
  logic [1:0] bank_out_sel_ff;
  logic [2:0] alu_op_ff;
  logic [7:0] imm_data_ff;
  logic       out_strobe_ff;
  logic       illegal_op_ff;
  logic       halted_ff;

  int checks = 0;
  int errors = 0;

  logic [7:0] model_pc;
  logic [7:0] model_imm;

  logic [16:0] ctrl;
  logic [16:0] ctrl_ff;

  assign ctrl    = {acc_sel, source_sel, destination_sel, alu_b_sel,
                    bank_out_sel, alu_op, out_strobe, illegal_op};
  assign ctrl_ff = {acc_sel_ff, source_sel_ff, destination_sel_ff, alu_b_sel_ff,
                    bank_out_sel_ff, alu_op_ff, out_strobe_ff, illegal_op_ff};

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .instr_data     (instr_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .pc             (pc),
    .acc_sel        (acc_sel),
    .source_sel     (source_sel),
    .destination_sel(destination_sel),
    .alu_b_sel      (alu_b_sel),
    .bank_out_sel   (bank_out_sel),
    .alu_op         (alu_op),
    .imm_data       (imm_data),
    .out_strobe     (out_strobe),
    .illegal_op     (illegal_op),
    .halted         (halted)
  );

  control_sequencer #(.RESET_PC(8'hFF)) dut_ff (
    .clk            (clk),
    .reset          (reset),
    .instr_data     (instr_data_ff),
    .instr_valid    (instr_valid_ff),
    .instr_ready    (instr_ready_ff),
    .pc             (pc_ff),
    .acc_sel        (acc_sel_ff),
    .source_sel     (source_sel_ff),
    .destination_sel(destination_sel_ff),
    .alu_b_sel      (alu_b_sel_ff),
    .bank_out_sel   (bank_out_sel_ff),
    .alu_op         (alu_op_ff),
    .imm_data       (imm_data_ff),
    .out_strobe     (out_strobe_ff),
    .illegal_op     (illegal_op_ff),
    .halted         (halted_ff)
  );

  // Instruction-level meaning of a byte, packed in the same order as ctrl:
  // {acc_sel, source_sel, destination_sel, alu_b_sel, bank_out_sel,
  //  alu_op, out_strobe, illegal_op}
  function automatic logic [16:0] exp_ctrl(input logic [7:0] b);
    int op, dst, src;
    logic       acc;
    logic [2:0] ss;
    logic [3:0] ds;
    logic [1:0] ab, bo;
    logic [2:0] ao;
    logic       st, il;
    op  = int'(b) / 16;
    dst = (int'(b) / 4) % 4;
    src = int'(b) % 4;
    acc = 1'b0; ss = 3'd0; ds = 4'd0; ab = 2'd0; bo = 2'd0;
    ao = 3'd0; st = 1'b0; il = 1'b0;
    if (op == 1) begin
      acc = 1'b1; ss = 3'(src); ds = 4'(1 << dst);
    end else if (op == 2) begin
      acc = 1'b1; ss = 3'd4; ds = 4'(1 << dst);
    end else if (op >= 3 && op <= 7) begin
      ab = 2'(src); ao = 3'(op - 3); ds = 4'd1;
    end else if (op == 8) begin
      bo = 2'(src); st = 1'b1;
    end else if (op >= 9 && op <= 14) begin
      il = 1'b1;
    end
    return {acc, ss, ds, ab, bo, ao, st, il};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset       = 1'b0;
    instr_valid = 1'b1;
    instr_data  = 8'h19;
    repeat (3) tick();
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_ready: got %b expected 1", instr_ready);
    end
    checks++;
    if (pc !== 8'h00) begin
      errors++; $display("[TB] FAIL reset_pc: got %h expected 00", pc);
    end
    checks++;
    if (ctrl !== 17'd0 || halted !== 1'b0 || imm_data !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got ctrl %h halted %b imm %h expected 0",
               ctrl, halted, imm_data);
    end
    checks++;
    if (pc_ff !== 8'hFF) begin
      errors++; $display("[TB] FAIL reset_pc_ff: got %h expected ff", pc_ff);
    end
    instr_valid = 1'b0;
    reset       = 1'b1;
    model_pc    = 8'h00;
    model_imm   = 8'h00;
  endtask

  // Runs one instruction through the primary instance starting from a FETCH
  // cycle, checking every cycle until the sequencer is back in FETCH.
  task automatic exec_instr(input logic [7:0] b, input logic [7:0] imm,
                            input int pre_dly, input int imm_dly);
    logic [16:0] want;
    for (int i = 0; i < pre_dly; i++) begin
      instr_valid = 1'b0;
      instr_data  = 8'($urandom);
      checks++;
      if (instr_ready !== 1'b1 || ctrl !== 17'd0 || pc !== model_pc) begin
        errors++;
        $display("[TB] FAIL idle_fetch: got ready %b ctrl %h pc %h expected 1 0 %h",
                 instr_ready, ctrl, pc, model_pc);
      end
      tick();
    end
    instr_valid = 1'b1;
    instr_data  = b;
    checks++;
    if (instr_ready !== 1'b1 || pc !== model_pc) begin
      errors++;
      $display("[TB] FAIL fetch: got ready %b pc %h expected 1 %h", instr_ready, pc, model_pc);
    end
    tick();
    model_pc = model_pc + 8'd1;

    instr_valid = 1'b1;
    instr_data  = 8'($urandom);
    checks++;
    if (instr_ready !== 1'b0 || ctrl !== 17'd0 || pc !== model_pc) begin
      errors++;
      $display("[TB] FAIL decode: got ready %b ctrl %h pc %h expected 0 0 %h",
               instr_ready, ctrl, pc, model_pc);
    end
    tick();

    if (b[7:4] == 4'b0010) begin
      for (int i = 0; i < imm_dly; i++) begin
        instr_valid = 1'b0;
        instr_data  = 8'($urandom);
        checks++;
        if (instr_ready !== 1'b1 || ctrl !== 17'd0 || pc !== model_pc) begin
          errors++;
          $display("[TB] FAIL imm_wait: got ready %b ctrl %h pc %h expected 1 0 %h",
                   instr_ready, ctrl, pc, model_pc);
        end
        tick();
      end
      instr_valid = 1'b1;
      instr_data  = imm;
      checks++;
      if (instr_ready !== 1'b1) begin
        errors++; $display("[TB] FAIL imm_fetch: got ready %b expected 1", instr_ready);
      end
      tick();
      model_pc  = model_pc + 8'd1;
      model_imm = imm;
    end

    want        = exp_ctrl(b);
    instr_valid = 1'b1;
    instr_data  = 8'($urandom);
    checks++;
    if (ctrl !== want) begin
      errors++;
      $display("[TB] FAIL execute_ctrl(%h): got %h expected %h", b, ctrl, want);
    end
    checks++;
    if (instr_ready !== 1'b0 || pc !== model_pc || imm_data !== model_imm || halted !== 1'b0) begin
      errors++;
      $display("[TB] FAIL execute_state(%h): got ready %b pc %h imm %h halted %b expected 0 %h %h 0",
               b, instr_ready, pc, imm_data, halted, model_pc, model_imm);
    end
    tick();
    instr_valid = 1'b0;
    checks++;
    if (instr_ready !== 1'b1 || ctrl !== 17'd0) begin
      errors++;
      $display("[TB] FAIL refetch: got ready %b ctrl %h expected 1 0", instr_ready, ctrl);
    end
  endtask

  task automatic test_mov();
    exec_instr(8'h19, 8'h00, 0, 0);
    checks++;
    if (pc !== 8'h01) begin
      errors++; $display("[TB] FAIL mov_pc: got %h expected 01", pc);
    end
  endtask

  task automatic test_ldi();
    exec_instr(8'h2C, 8'h5A, 0, 3);
    checks++;
    if (imm_data !== 8'h5A || pc !== 8'h03) begin
      errors++;
      $display("[TB] FAIL ldi_result: got imm %h pc %h expected 5a 03", imm_data, pc);
    end
  endtask

  task automatic test_alu();
    exec_instr(8'h33, 8'h00, 1, 0);
    exec_instr(8'h40, 8'h00, 0, 0);
    for (int op = 3; op <= 7; op++) begin
      exec_instr(8'((op * 16) + int'($urandom_range(0, 15))), 8'h00, 0, 0);
    end
  endtask

  task automatic test_illegal_out();
    exec_instr(8'hA0, 8'h00, 0, 0);
    exec_instr(8'h82, 8'h00, 2, 0);
    exec_instr(8'h00, 8'h00, 0, 0);
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    for (int n = 0; n < 40; n++) begin
      b = 8'($urandom);
      if (b[7:4] == 4'hF) b[7:4] = 4'h2;
      exec_instr(b, 8'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
    end
  endtask

  task automatic test_reset_mid_ldi();
    instr_valid = 1'b1;
    instr_data  = 8'h2D;
    tick();
    instr_data  = 8'h00;
    tick();
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL mid_ldi_imm_phase: got ready %b expected 1", instr_ready);
    end
    reset       = 1'b0;
    instr_valid = 1'b1;
    instr_data  = 8'h77;
    tick();
    reset       = 1'b1;
    instr_valid = 1'b0;
    model_pc    = 8'h00;
    model_imm   = 8'h00;
    checks++;
    if (instr_ready !== 1'b1 || pc !== 8'h00 || imm_data !== 8'h00 || ctrl !== 17'd0) begin
      errors++;
      $display("[TB] FAIL mid_ldi_reset: got ready %b pc %h imm %h ctrl %h expected 1 00 00 0",
               instr_ready, pc, imm_data, ctrl);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (destination_sel !== 4'd0 || instr_ready !== 1'b1 || pc !== 8'h00) begin
        errors++;
        $display("[TB] FAIL mid_ldi_quiet: got dest %b ready %b pc %h expected 0000 1 00",
                 destination_sel, instr_ready, pc);
      end
    end
  endtask

  task automatic test_halt_wrap();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++;
    if (instr_ready_ff !== 1'b1 || pc_ff !== 8'hFF) begin
      errors++;
      $display("[TB] FAIL halt_start: got ready %b pc %h expected 1 ff", instr_ready_ff, pc_ff);
    end
    instr_valid_ff = 1'b1;
    instr_data_ff  = 8'hF0;
    tick();
    instr_data_ff  = 8'h19;
    checks++;
    if (pc_ff !== 8'h00 || instr_ready_ff !== 1'b0 || halted_ff !== 1'b0) begin
      errors++;
      $display("[TB] FAIL halt_wrap: got pc %h ready %b halted %b expected 00 0 0",
               pc_ff, instr_ready_ff, halted_ff);
    end
    tick();
    checks++;
    if (ctrl_ff !== 17'd0 || halted_ff !== 1'b0) begin
      errors++;
      $display("[TB] FAIL halt_execute: got ctrl %h halted %b expected 0 0", ctrl_ff, halted_ff);
    end
    tick();
    for (int i = 0; i < 10; i++) begin
      instr_data_ff = 8'($urandom);
      checks++;
      if (halted_ff !== 1'b1 || instr_ready_ff !== 1'b0 || pc_ff !== 8'h00 || ctrl_ff !== 17'd0) begin
        errors++;
        $display("[TB] FAIL halt_hold: got halted %b ready %b pc %h ctrl %h expected 1 0 00 0",
                 halted_ff, instr_ready_ff, pc_ff, ctrl_ff);
      end
      tick();
    end
    reset = 1'b0;
    tick();
    reset          = 1'b1;
    instr_valid_ff = 1'b0;
    checks++;
    if (halted_ff !== 1'b0 || instr_ready_ff !== 1'b1 || pc_ff !== 8'hFF) begin
      errors++;
      $display("[TB] FAIL halt_exit: got halted %b ready %b pc %h expected 0 1 ff",
               halted_ff, instr_ready_ff, pc_ff);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_mov();
    test_ldi();
    test_alu();
    test_illegal_out();
    test_back_to_back();
    test_reset_mid_ldi();
    test_halt_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
